// File: rtl/pio_edge_capture_in.sv
// Input PIO for the lightweight HPS-to-FPGA bridge: synchronised inputs,
// per-bit edge capture with write-1-to-clear, interrupt mask and level irq.
module pio_edge_capture_in #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int unsigned PRIME_MAX = SYNC_STAGES + 1;
  localparam int unsigned CNT_W     = $clog2(PRIME_MAX + 1);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_CAPT = 2'd3;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  prev_q;
  logic [CNT_W-1:0]                  prime_cnt_q;
  logic [WIDTH-1:0]                  mask_q;
  logic [WIDTH-1:0]                  capture_q;

  logic [WIDTH-1:0] synced;
  logic             primed;
  logic             wr;
  logic [WIDTH-1:0] raw_edge;
  logic [WIDTH-1:0] edge_vec;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] capture_next;
  logic [WIDTH-1:0] mask_next;
  logic [31:0]      rd_next;
  logic             unused_wd;

  assign synced    = sync_q[SYNC_STAGES-1];
  assign primed    = (prime_cnt_q == CNT_W'(PRIME_MAX));
  assign wr        = chipselect & ~write_n;
  assign unused_wd = ^writedata;

  // Edge selection; suppressed until the chain and prev hold real samples
  always_comb begin
    raw_edge = '0;
    case (EDGE_TYPE)
      0:       raw_edge = synced & ~prev_q;
      1:       raw_edge = ~synced & prev_q;
      default: raw_edge = synced ^ prev_q;
    endcase
    edge_vec = primed ? raw_edge : '0;
  end

  // Register-file next state; a same-cycle edge overrides a clear
  always_comb begin
    clr       = '0;
    mask_next = mask_q;
    if (wr && address == ADDR_CAPT) clr = writedata[WIDTH-1:0];
    if (wr && address == ADDR_MASK) mask_next = writedata[WIDTH-1:0];
    capture_next = (capture_q & ~clr) | edge_vec;
  end

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA: rd_next = 32'(synced);
      ADDR_MASK: rd_next = 32'(mask_q);
      ADDR_CAPT: rd_next = 32'(capture_q);
      default:   rd_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q      <= '0;
      prev_q      <= '0;
      prime_cnt_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
      prev_q <= synced;
      if (!primed) prime_cnt_q <= prime_cnt_q + CNT_W'(1);
    end
  end

  // irq follows the registered capture/mask, so it lags them by one clock
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mask_q    <= '0;
      capture_q <= '0;
      irq       <= 1'b0;
      readdata  <= '0;
    end else begin
      mask_q    <= mask_next;
      capture_q <= capture_next;
      irq       <= |(capture_q & mask_q);
      readdata  <= rd_next;
    end
  end

endmodule
